goto_seq_gen: RTL and testbench

Stimulus generator producing the goto-repetition handshake `a |=> b[->B_COUNT] ##1 c`. A one-cycle request on `a` starts a burst of exactly `B_COUNT` pulses on `b`, which may be non-consecutive. Gaps are inserted cycle-by-cycle via `hold`, and `c` is asserted for one cycle immediately after the last `b`. The block sits on the driving side of the a/b/c interface and is the counterpart of the assertion-based checker, used as a DUT and as a bench-side sequence source.

---
 rtl/goto_seq_gen_if.sv | 13 +
 rtl/goto_seq_gen.sv | 87 ++++++++
 tb/tb_goto_seq_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/goto_seq_gen_if.sv
// Request/response bundle for the goto-repetition generator: the requester (master)
// drives a/hold, the generator (slave) drives b/c/busy/b_cnt.
interface goto_seq_if;
  logic       a;
  logic       hold;
  logic       b;
  logic       c;
  logic       busy;
  logic [3:0] b_cnt;

  modport master (output a, hold, input b, c, busy, b_cnt);
  modport slave  (input a, hold, output b, c, busy, b_cnt);
endinterface

// File: rtl/goto_seq_gen.sv
// Drives the sequence a |=> b[->B_COUNT] ##1 c, with hold inserting gaps between b pulses.
// Optional embedded self-check assertions: define GOTO_SEQ_GEN_ASSERT_EN.
module goto_seq_gen #(
  parameter int unsigned B_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  goto_seq_if.slave  bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam logic [3:0] BC = 4'(B_COUNT);

  state_t     state_q;
  logic       b_q;
  logic       c_q;
  logic [3:0] b_cnt_q;
  logic [3:0] b_cnt_inc;

  // Only evaluated in RUN, where b_cnt_q < B_COUNT <= 15, so this never wraps.
  assign b_cnt_inc = b_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      b_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          c_q <= 1'b0;
          if (bus.a) begin
            b_q     <= !bus.hold;
            b_cnt_q <= {3'b000, !bus.hold};
            state_q <= (BC == 4'd1 && !bus.hold) ? TAIL : RUN;
          end else begin
            b_q <= 1'b0;
          end
        end
        RUN: begin
          c_q <= 1'b0;
          b_q <= !bus.hold;
          if (!bus.hold) begin
            b_cnt_q <= b_cnt_inc;
            if (b_cnt_inc == BC) state_q <= TAIL;
          end
        end
        TAIL: begin
          b_q     <= 1'b0;
          c_q     <= 1'b1;
          b_cnt_q <= 4'd0;
          state_q <= IDLE;
        end
        default: begin
          b_q     <= 1'b0;
          c_q     <= 1'b0;
          b_cnt_q <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.b     = b_q;
  assign bus.c     = c_q;
  assign bus.b_cnt = b_cnt_q;
  assign bus.busy  = (state_q == RUN) || (state_q == TAIL);
  assign state_o   = state_q;

`ifdef GOTO_SEQ_GEN_ASSERT_EN
  a_goto_seq: assert property (@(posedge clk) disable iff (rst)
    (bus.a && !bus.busy) |=> bus.b[->B_COUNT] ##1 bus.c);
  a_c_excl_b: assert property (@(posedge clk) disable iff (rst)
    bus.c |-> !bus.b);
  a_c_single: assert property (@(posedge clk) disable iff (rst)
    $rose(bus.c) |=> !bus.c);
`else
`endif

endmodule

// File: tb/tb_goto_seq_gen.sv
// Scoreboarded bench for goto_seq_gen with B_COUNT=3 and B_COUNT=1 instances.
module tb_goto_seq_gen;

  logic       clk;
  logic       rst;
  logic [1:0] state3;
  logic [1:0] state1;
  int         cyc;
  int         t0_3;
  int         t0_1;
  int         n_vec;
  int         n_err;

  // Entry layout: {rel_cycle[7:0], busy, b, c, b_cnt[3:0]}
  logic [14:0] exp3_q[$];
  logic [14:0] exp1_q[$];

  goto_seq_if if3 ();
  goto_seq_if if1 ();

  goto_seq_gen #(.B_COUNT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave), .state_o(state3));
  goto_seq_gen #(.B_COUNT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .state_o(state1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // driver helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [14:0] ev(input int rel, input logic bs, input logic bb,
                                     input logic cc, input int cnt);
    logic [7:0] r;
    logic [3:0] k;
    r = rel[7:0];
    k = cnt[3:0];
    return {r, bs, bb, cc, k};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    check({name, "_drain3"}, exp3_q.size(), 0);
    check({name, "_drain1"}, exp1_q.size(), 0);
    exp3_q.delete();
    exp1_q.delete();
  endtask

  // monitor: any cycle where busy/b/c is up is an output event
  always @(negedge clk) begin
    logic [14:0] got;
    logic [14:0] want;
    if (if3.busy || if3.b || if3.c) begin
      got = {8'(cyc - t0_3), if3.busy, if3.b, if3.c, if3.b_cnt};
      n_vec++;
      if (exp3_q.size() == 0) begin
        n_err++;
        $display("FAIL dut3_unexpected: got rel=%0d busy/b/c=%b cnt=%0d expected no event",
                 got[14:7], got[6:4], got[3:0]);
      end else begin
        want = exp3_q.pop_front();
        if (got != want) begin
          n_err++;
          $display("FAIL dut3_event: got rel=%0d busy/b/c=%b cnt=%0d expected rel=%0d busy/b/c=%b cnt=%0d",
                   got[14:7], got[6:4], got[3:0], want[14:7], want[6:4], want[3:0]);
        end
      end
    end
    if (if1.busy || if1.b || if1.c) begin
      got = {8'(cyc - t0_1), if1.busy, if1.b, if1.c, if1.b_cnt};
      n_vec++;
      if (exp1_q.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected: got rel=%0d busy/b/c=%b cnt=%0d expected no event",
                 got[14:7], got[6:4], got[3:0]);
      end else begin
        want = exp1_q.pop_front();
        if (got != want) begin
          n_err++;
          $display("FAIL dut1_event: got rel=%0d busy/b/c=%b cnt=%0d expected rel=%0d busy/b/c=%b cnt=%0d",
                   got[14:7], got[6:4], got[3:0], want[14:7], want[6:4], want[3:0]);
        end
      end
    end
  end

  initial begin
    cyc    = 0;
    t0_3   = 0;
    t0_1   = 0;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    if3.a = 1'b0; if3.hold = 1'b0;
    if1.a = 1'b0; if1.hold = 1'b0;
    tick(3);

    // reset values
    check("rst_b", int'(if3.b), 0);
    check("rst_c", int'(if3.c), 0);
    check("rst_busy", int'(if3.busy), 0);
    check("rst_cnt", int'(if3.b_cnt), 0);
    rst = 1'b0;
    tick(2);

    // pass burst
    t0_3 = cyc;
    exp3_q.push_back(ev(1, 1, 1, 0, 1));
    exp3_q.push_back(ev(2, 1, 1, 0, 2));
    exp3_q.push_back(ev(3, 1, 1, 0, 3));
    exp3_q.push_back(ev(4, 0, 0, 1, 0));
    if3.a = 1'b1; tick(1);
    if3.a = 1'b0; tick(7);
    drain("pass");

    // gapped burst: hold at T1 and T3
    t0_3 = cyc;
    exp3_q.push_back(ev(1, 1, 1, 0, 1));
    exp3_q.push_back(ev(2, 1, 0, 0, 1));
    exp3_q.push_back(ev(3, 1, 1, 0, 2));
    exp3_q.push_back(ev(4, 1, 0, 0, 2));
    exp3_q.push_back(ev(5, 1, 1, 0, 3));
    exp3_q.push_back(ev(6, 0, 0, 1, 0));
    if3.a = 1'b1; if3.hold = 1'b0; tick(1);
    if3.a = 1'b0; if3.hold = 1'b1; tick(1);
    if3.hold = 1'b0; tick(1);
    if3.hold = 1'b1; tick(1);
    if3.hold = 1'b0; tick(6);
    drain("gapped");

    // leading gap: hold at T0, and hold during TAIL is ignored
    t0_3 = cyc;
    exp3_q.push_back(ev(1, 1, 0, 0, 0));
    exp3_q.push_back(ev(2, 1, 1, 0, 1));
    exp3_q.push_back(ev(3, 1, 1, 0, 2));
    exp3_q.push_back(ev(4, 1, 1, 0, 3));
    exp3_q.push_back(ev(5, 0, 0, 1, 0));
    if3.a = 1'b1; if3.hold = 1'b1; tick(1);
    if3.a = 1'b0; if3.hold = 1'b0; tick(3);
    if3.hold = 1'b1; tick(1);
    if3.hold = 1'b0; tick(5);
    drain("lead_gap");

    // ignored request at T2
    t0_3 = cyc;
    exp3_q.push_back(ev(1, 1, 1, 0, 1));
    exp3_q.push_back(ev(2, 1, 1, 0, 2));
    exp3_q.push_back(ev(3, 1, 1, 0, 3));
    exp3_q.push_back(ev(4, 0, 0, 1, 0));
    if3.a = 1'b1; tick(1);
    if3.a = 1'b0; tick(1);
    if3.a = 1'b1; tick(1);
    if3.a = 1'b0; tick(8);
    drain("ignored");

    // back-to-back: a high on edges T0..T7
    t0_3 = cyc;
    for (int i = 1; i <= 3; i++) exp3_q.push_back(ev(i, 1, 1, 0, i));
    exp3_q.push_back(ev(4, 0, 0, 1, 0));
    for (int i = 1; i <= 3; i++) exp3_q.push_back(ev(4 + i, 1, 1, 0, i));
    exp3_q.push_back(ev(8, 0, 0, 1, 0));
    if3.a = 1'b1; tick(8);
    if3.a = 1'b0; tick(6);
    drain("b2b");

    // reset mid-burst at edge T2
    t0_3 = cyc;
    exp3_q.push_back(ev(1, 1, 1, 0, 1));
    exp3_q.push_back(ev(2, 1, 1, 0, 2));
    if3.a = 1'b1; tick(1);
    if3.a = 1'b0; tick(1);
    rst = 1'b1; tick(1);
    check("midrst_b", int'(if3.b), 0);
    check("midrst_c", int'(if3.c), 0);
    check("midrst_busy", int'(if3.busy), 0);
    check("midrst_cnt", int'(if3.b_cnt), 0);
    rst = 1'b0; tick(8);
    drain("midrst");

    // B_COUNT=1 run after reset
    t0_1 = cyc;
    exp1_q.push_back(ev(1, 1, 1, 0, 1));
    exp1_q.push_back(ev(2, 0, 0, 1, 0));
    if1.a = 1'b1; tick(1);
    if1.a = 1'b0; tick(5);
    drain("bc1");

    // B_COUNT=1 with leading gap
    t0_1 = cyc;
    exp1_q.push_back(ev(1, 1, 0, 0, 0));
    exp1_q.push_back(ev(2, 1, 1, 0, 1));
    exp1_q.push_back(ev(3, 0, 0, 1, 0));
    if1.a = 1'b1; if1.hold = 1'b1; tick(1);
    if1.a = 1'b0; if1.hold = 1'b0; tick(5);
    drain("bc1_gap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
